// File: rtl/shift_req_arbiter.sv
// Two-requester round-robin front end for a shared rotate unit.
// One op in flight; each op walks Idle -> Exec -> Resp and returns a tagged result.

module multi_barrel_shifter_top #(
  parameter int unsigned N = 3
) (
  input  logic [2**N-1:0] data,
  input  logic [N-1:0]    amt,
  input  logic            lr,
  output logic [2**N-1:0] out
);
  localparam int unsigned W = 2**N;

  logic [W-1:0]   stage;
  logic [2*W-1:0] dbl;

  // Log-depth rotator: stage i rotates by 2**i when amt[i] is set.
  always_comb begin
    stage = data;
    dbl   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (amt[i]) begin
        dbl = {stage, stage};
        if (lr) begin
          dbl   = dbl << (1 << i);
          stage = dbl[2*W-1:W];
        end else begin
          dbl   = dbl >> (1 << i);
          stage = dbl[W-1:0];
        end
      end
    end
    out = stage;
  end
endmodule

module shift_req_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [2**N-1:0] a_data,
  input  logic [N-1:0]    a_amt,
  input  logic            a_lr,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [2**N-1:0] b_data,
  input  logic [N-1:0]    b_amt,
  input  logic            b_lr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2**N-1:0] rsp_data,
  output logic            rsp_id
);
  localparam int unsigned W = 2**N;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;  // 1 = B was granted last
  logic [W-1:0]   op_data_q, op_data_d;
  logic [N-1:0]   op_amt_q, op_amt_d;
  logic           op_lr_q, op_lr_d;
  logic           op_id_q, op_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_id_q, rsp_id_d;
  logic           grant_b;
  logic           grant_any;
  logic [W-1:0]   shift_out;

  multi_barrel_shifter_top #(
    .N (N)
  ) u_shifter (
    .data (op_data_q),
    .amt  (op_amt_q),
    .lr   (op_lr_q),
    .out  (shift_out)
  );

  always_comb begin
    grant_any = a_valid | b_valid;
    grant_b   = b_valid;
    if (a_valid && b_valid) begin
      grant_b = ~last_grant_q;
    end
  end

  assign a_ready = (state_q == StIdle) & a_valid & ~grant_b;
  assign b_ready = (state_q == StIdle) & b_valid & grant_b;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_data_d    = op_data_q;
    op_amt_d     = op_amt_q;
    op_lr_d      = op_lr_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          op_data_d    = grant_b ? b_data : a_data;
          op_amt_d     = grant_b ? b_amt : a_amt;
          op_lr_d      = grant_b ? b_lr : a_lr;
          op_id_d      = grant_b;
          last_grant_d = grant_b;
          state_d      = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = shift_out;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      op_data_q    <= '0;
      op_amt_q     <= '0;
      op_lr_q      <= 1'b0;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_data_q    <= op_data_d;
      op_amt_q     <= op_amt_d;
      op_lr_q      <= op_lr_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
endmodule
